width_reader: RTL

Receive-side decoder for the switch-coded pulse link. The transmit end holds its serial line high for a number of baud ticks set by the four switches. This block measures that width on the shared baud tick and recovers the 4-bit switch code. It reports the code with a one-cycle valid strobe, or an error strobe when the width matches no legal code. It sits on the `sysclk` domain beside `clockdiv`, and takes that divider's tick as a clock enable.

---
 rtl/width_pkg.sv | 29 ++
 rtl/width_lookup.sv | 33 +++
 rtl/width_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/width_pkg.sv
// Shared constants, state encoding and subset-sum helper for the pulse-width decoder.
package width_pkg;

    localparam logic [8:0] W_SW1   = 9'd120;
    localparam logic [8:0] W_SW2   = 9'd109;
    localparam logic [8:0] W_SW3   = 9'd76;
    localparam logic [8:0] W_SW4   = 9'd43;
    localparam logic [8:0] CNT_MAX = 9'd511;

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        MEAS,
        OVF,
        DONE
    } state_t;

    // Width the transmitter encodes for a switch pattern; max 348, fits in 9 bits.
    function automatic logic [8:0] subset_sum(input logic [3:0] sw);
        logic [8:0] s;
        s = '0;
        if (sw[0]) s = s + W_SW1;
        if (sw[1]) s = s + W_SW2;
        if (sw[2]) s = s + W_SW3;
        if (sw[3]) s = s + W_SW4;
        return s;
    endfunction

endpackage

// File: rtl/width_lookup.sv
// Combinational map from a measured width to the first matching switch code.
module width_lookup
    import width_pkg::*;
#(
    parameter int unsigned TOL = 0
) (
    input  logic [8:0] value,
    output logic       hit,
    output logic [3:0] code
);

    localparam logic [8:0] TOL_W = 9'(TOL);

    logic [8:0] sum;
    logic [8:0] diff;

    // Scan codes 1..15 in ascending order; the first one within tolerance wins.
    always_comb begin
        hit  = 1'b0;
        code = '0;
        sum  = '0;
        diff = '0;
        for (int unsigned c = 1; c < 16; c++) begin
            sum  = subset_sum(4'(c));
            diff = (value >= sum) ? (value - sum) : (sum - value);
            if (!hit && (diff <= TOL_W)) begin
                hit  = 1'b1;
                code = 4'(c);
            end
        end
    end

endmodule

// File: rtl/width_reader.sv
// Receive-side decoder: measures the high width of line_in in baud ticks and
// recovers the 4-bit switch code, strobing valid or err once per pulse.
module width_reader
    import width_pkg::*;
#(
    parameter int unsigned MIN_W = 4,
    parameter int unsigned TOL   = 0
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       tick,
    input  logic       line_in,
    output logic [3:0] code,
    output logic [8:0] width,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    localparam logic [8:0] MIN_W9 = 9'(MIN_W);

    logic       sync_q1;
    logic       line_s;
    state_t     state;
    state_t     state_nxt;
    logic [8:0] cnt;
    logic [8:0] value;
    logic       hit;
    logic [3:0] hit_code;
    logic       meas_end;

    assign value    = cnt - 9'd1;
    assign meas_end = tick && !line_s && ((state == MEAS) || (state == OVF));
    assign busy     = (state == MEAS) || (state == OVF);

    width_lookup #(
        .TOL (TOL)
    ) u_lookup (
        .value (value),
        .hit   (hit),
        .code  (hit_code)
    );

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            line_s  <= 1'b0;
        end else begin
            sync_q1 <= line_in;
            line_s  <= sync_q1;
        end
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) state <= ARM;
        else       state <= state_nxt;
    end

    // Next-state logic; all transitions except DONE->IDLE wait for a tick.
    always_comb begin
        state_nxt = state;
        case (state)
            ARM:  if (tick && !line_s) state_nxt = IDLE;
            IDLE: if (tick && line_s)  state_nxt = MEAS;
            MEAS: begin
                if (tick) begin
                    if (!line_s)                       state_nxt = DONE;
                    else if (cnt >= CNT_MAX - 9'd1)    state_nxt = OVF;
                end
            end
            OVF:  if (tick && !line_s) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = ARM;
        endcase
    end

    // High-tick counter: loads 1 on the first high tick, saturates at CNT_MAX.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick && line_s) begin
            if (state == IDLE)                         cnt <= 9'd1;
            else if (state == MEAS && cnt != CNT_MAX)  cnt <= cnt + 9'd1;
        end
    end

    // Result registers. Decode is captured on the closing tick so the strobe
    // occupies exactly the DONE cycle; code/width hold until the next strobe.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            code  <= '0;
            width <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (meas_end) begin
                if (state == OVF) begin
                    err   <= 1'b1;
                    code  <= '0;
                    width <= CNT_MAX;
                end else if (cnt >= MIN_W9) begin
                    if (hit) begin
                        valid <= 1'b1;
                        code  <= hit_code;
                        width <= value;
                    end else begin
                        err   <= 1'b1;
                        code  <= '0;
                        width <= value;
                    end
                end
            end
        end
    end

endmodule
